// File: rtl/mmcm_drp_sequencer.sv
// mmcm_drp_sequencer
// Bridges single-cycle register-side DRP requests onto the MMCM DRP port.
// Every access issues exactly one den pulse and then waits for drdy, with a
// timeout. Writes are done as a read followed by a masked merge write.
// Optional build macro: DRP_AUTO_RESET_EN. When defined, writes hold the
// MMCM in reset across the DRP access and wait for lock before finishing.
module mmcm_drp_sequencer #(
  parameter int pTIMEOUT  = 1023,
  parameter int pTO_WIDTH = 10
) (
  input  logic        clk_usb,
  input  logic        reset_i,
  input  logic [6:0]  req_addr,
  input  logic        req_den,
  input  logic        req_dwe,
  input  logic [15:0] req_din,
  input  logic [15:0] req_mask,
  output logic [15:0] req_dout,
  output logic        req_done,
  output logic        busy,
  output logic        timeout_err,
  output logic        overrun_err,
  output logic [6:0]  mmcm_daddr,
  output logic        mmcm_den,
  output logic        mmcm_dwe,
  output logic [15:0] mmcm_di,
  input  logic [15:0] mmcm_do,
  input  logic        mmcm_drdy,
  output logic        mmcm_rst,
  input  logic        mmcm_locked
);

  typedef enum logic [2:0] {
    IDLE,
    RST,
    RD,
    RD_WAIT,
    WR,
    WR_WAIT,
    LOCK_WAIT,
    DONE
  } state_t;

  state_t state, state_next;

  logic [6:0]           addr_q;
  logic                 dwe_q;
  logic [15:0]          din_q;
  logic [15:0]          mask_q;
  logic [15:0]          rdata_q;
  logic [pTO_WIDTH-1:0] to_cnt;
  logic                 timeout_q;
  logic                 overrun_q;
  logic                 accept;
  logic                 to_hit;
  logic                 timeout_hit;
  logic                 in_wait;
  logic [15:0]          merged;
  logic                 locked_s;

`ifdef DRP_AUTO_RESET_EN
  logic [1:0] lock_sync;
  logic       rst_q;

  // Two-flop synchronizer for the asynchronous MMCM lock signal
  always_ff @(posedge clk_usb) begin
    if (reset_i) lock_sync <= 2'b00;
    else         lock_sync <= {lock_sync[0], mmcm_locked};
  end

  assign locked_s = lock_sync[1];

  // MMCM reset rises with an accepted write and falls once the DRP write is
  // acknowledged (entry to LOCK_WAIT) or the transaction aborts
  always_ff @(posedge clk_usb) begin
    if (reset_i)
      rst_q <= 1'b0;
    else if (state == IDLE)
      rst_q <= accept && req_dwe;
    else
      rst_q <= rst_q && (state_next inside {RST, RD, RD_WAIT, WR, WR_WAIT});
  end

  assign mmcm_rst = rst_q;
`else
  logic locked_unused;

  assign locked_unused = mmcm_locked;
  assign locked_s      = 1'b0;
  assign mmcm_rst      = 1'b0;
`endif

  assign accept  = (state == IDLE) && req_den;
  assign to_hit  = (to_cnt == pTO_WIDTH'(pTIMEOUT - 1));
  assign in_wait = (state == RD_WAIT) || (state == WR_WAIT) || (state == LOCK_WAIT);
  assign merged  = (rdata_q & mask_q) | (din_q & ~mask_q);

  // State register
  always_ff @(posedge clk_usb) begin
    if (reset_i) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state selection and timeout detection in the wait states
  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (req_den) begin
`ifdef DRP_AUTO_RESET_EN
          state_next = req_dwe ? RST : RD;
`else
          state_next = RD;
`endif
        end
      end
      RST:     state_next = RD;
      RD:      state_next = RD_WAIT;
      RD_WAIT: begin
        if (mmcm_drdy) begin
          state_next = dwe_q ? WR : DONE;
        end else if (to_hit) begin
          state_next  = DONE;
          timeout_hit = 1'b1;
        end
      end
      WR:      state_next = WR_WAIT;
      WR_WAIT: begin
        if (mmcm_drdy) begin
`ifdef DRP_AUTO_RESET_EN
          state_next = LOCK_WAIT;
`else
          state_next = DONE;
`endif
        end else if (to_hit) begin
          state_next  = DONE;
          timeout_hit = 1'b1;
        end
      end
      LOCK_WAIT: begin
        if (locked_s) begin
          state_next = DONE;
        end else if (to_hit) begin
          state_next  = DONE;
          timeout_hit = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the request fields when a new request is accepted
  always_ff @(posedge clk_usb) begin
    if (reset_i) begin
      addr_q <= '0;
      dwe_q  <= 1'b0;
      din_q  <= '0;
      mask_q <= '0;
    end else if (accept) begin
      addr_q <= req_addr;
      dwe_q  <= req_dwe;
      din_q  <= req_din;
      mask_q <= req_mask;
    end
  end

  // Timeout counter restarts on every state change and counts while waiting
  always_ff @(posedge clk_usb) begin
    if (reset_i)                  to_cnt <= '0;
    else if (state_next != state) to_cnt <= '0;
    else if (in_wait)             to_cnt <= to_cnt + 1'b1;
  end

  // Capture DRP read data; it is kept unchanged when an access times out
  always_ff @(posedge clk_usb) begin
    if (reset_i)                           rdata_q <= '0;
    else if (state == RD_WAIT && mmcm_drdy) rdata_q <= mmcm_do;
  end

  // Sticky error flags: timeout clears on a new request, overrun only on reset
  always_ff @(posedge clk_usb) begin
    if (reset_i) begin
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (accept)           timeout_q <= 1'b0;
      else if (timeout_hit) timeout_q <= 1'b1;
      if (req_den && state != IDLE) overrun_q <= 1'b1;
    end
  end

  assign req_dout    = rdata_q;
  assign req_done    = (state == DONE);
  assign busy        = (state != IDLE);
  assign timeout_err = timeout_q;
  assign overrun_err = overrun_q;
  assign mmcm_daddr  = addr_q;
  assign mmcm_den    = (state == RD) || (state == WR);
  assign mmcm_dwe    = (state == WR);
  assign mmcm_di     = (state == WR) ? merged : 16'h0000;

endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// tb_mmcm_drp_sequencer
// Scoreboard bench: each accepted request pushes its expected readback,
// timeout flag and (optionally) latency; req_done pops and compares.
// A behavioural MMCM DRP model with a lock model drives the DRP side.
// Optional build macro: DRP_AUTO_RESET_EN (must match the RTL build).
module tb_mmcm_drp_sequencer;

`ifdef DRP_AUTO_RESET_EN
  localparam int TO   = 64;
  localparam bit AUTO = 1'b1;
`else
  localparam int TO   = 16;
  localparam bit AUTO = 1'b0;
`endif

  logic        clk_usb = 1'b0;
  logic        reset_i;
  logic [6:0]  req_addr;
  logic        req_den;
  logic        req_dwe;
  logic [15:0] req_din;
  logic [15:0] req_mask;
  logic [15:0] req_dout;
  logic        req_done;
  logic        busy;
  logic        timeout_err;
  logic        overrun_err;
  logic [6:0]  mmcm_daddr;
  logic        mmcm_den;
  logic        mmcm_dwe;
  logic [15:0] mmcm_di;
  logic [15:0] mmcm_do;
  logic        mmcm_drdy;
  logic        mmcm_rst;
  logic        mmcm_locked;

  mmcm_drp_sequencer #(.pTIMEOUT(TO), .pTO_WIDTH(7)) dut (
    .clk_usb     (clk_usb),
    .reset_i     (reset_i),
    .req_addr    (req_addr),
    .req_den     (req_den),
    .req_dwe     (req_dwe),
    .req_din     (req_din),
    .req_mask    (req_mask),
    .req_dout    (req_dout),
    .req_done    (req_done),
    .busy        (busy),
    .timeout_err (timeout_err),
    .overrun_err (overrun_err),
    .mmcm_daddr  (mmcm_daddr),
    .mmcm_den    (mmcm_den),
    .mmcm_dwe    (mmcm_dwe),
    .mmcm_di     (mmcm_di),
    .mmcm_do     (mmcm_do),
    .mmcm_drdy   (mmcm_drdy),
    .mmcm_rst    (mmcm_rst),
    .mmcm_locked (mmcm_locked)
  );

  always #5 clk_usb = ~clk_usb;

  typedef struct {
    logic [15:0] dout;
    logic        terr;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          den_cnt = 0;
  int          dwe_cnt = 0;
  int          pend = 0;
  int          rd_lat = 1;
  int          wr_lat = 1;
  bit          drdy_on = 1'b1;
  int          lk_cnt = 0;
  logic        last_dwe = 1'b0;
  logic        rst_at_wr = 1'b0;
  logic [15:0] last_di = '0;
  logic [15:0] last_dout = '0;
  logic [15:0] mem[128];
  logic [15:0] ref_mem[128];
  int          d0, w0, dc0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk_usb) cyc++;

  // MMCM DRP model: one drdy per den after a programmable delay
  always @(negedge clk_usb) begin
    mmcm_drdy = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) mmcm_drdy = 1'b1;
    end
    if (mmcm_den) begin
      den_cnt++;
      last_dwe = mmcm_dwe;
      if (mmcm_dwe) begin
        dwe_cnt++;
        last_di   = mmcm_di;
        rst_at_wr = mmcm_rst;
        mem[mmcm_daddr] = mmcm_di;
      end else begin
        mmcm_do = mem[mmcm_daddr];
      end
      if (drdy_on) pend = mmcm_dwe ? wr_lat : rd_lat;
    end
  end

  // MMCM lock model: drops while in reset, relocks 20 cycles after release
  always @(negedge clk_usb) begin
    if (mmcm_rst) begin
      mmcm_locked = 1'b0;
      lk_cnt = 0;
    end else if (!mmcm_locked) begin
      lk_cnt++;
      if (lk_cnt == 20) mmcm_locked = 1'b1;
    end
  end

  // Completion monitor: pop expected result on every req_done
  always @(negedge clk_usb) begin
    if (req_done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checkOutput("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("req_dout", 32'(req_dout), 32'(e.dout));
        checkOutput("timeout_err_at_done", 32'(timeout_err), 32'(e.terr));
        if (e.lat > 0) checkOutput("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  task automatic issueRaw(input logic dwe, input logic [6:0] a, input logic [15:0] din,
                          input logic [15:0] mask);
    req_den  = 1'b1;
    req_dwe  = dwe;
    req_addr = a;
    req_din  = din;
    req_mask = mask;
    @(negedge clk_usb);
    req_den  = 1'b0;
  endtask

  task automatic applyStimulus(input logic dwe, input logic [6:0] a, input logic [15:0] din,
                               input logic [15:0] mask, input int lat);
    exp_t x;
    @(negedge clk_usb);
    x.dout = drdy_on ? ref_mem[a] : last_dout;
    x.terr = !drdy_on;
    x.lat  = lat;
    x.acc  = cyc;
    last_dout = x.dout;
    if (dwe && drdy_on) ref_mem[a] = (ref_mem[a] & mask) | (din & ~mask);
    sb.push_back(x);
    issueRaw(dwe, a, din, mask);
  endtask

  task automatic waitIdle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_usb);
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("wait_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk_usb);
  endtask

  task automatic doReset();
    @(negedge clk_usb);
    reset_i = 1'b1;
    repeat (2) @(negedge clk_usb);
    reset_i = 1'b0;
    last_dout = '0;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_i = 1'b0;
    req_den = 1'b0;
    req_dwe = 1'b0;
    req_addr = '0;
    req_din = '0;
    req_mask = '0;
    mmcm_do = '0;
    mmcm_drdy = 1'b0;
    mmcm_locked = 1'b1;
    for (int i = 0; i < 128; i++) begin
      mem[i]     = 16'(i * 16'h0101) ^ 16'hA5C3;
      ref_mem[i] = mem[i];
    end

    doReset();
    checkOutput("reset_flags", 32'({req_done, busy, timeout_err, overrun_err, mmcm_den, mmcm_dwe, mmcm_rst}), 32'd0);
    checkOutput("reset_dout", 32'(req_dout), 32'd0);
    checkOutput("reset_daddr_di", 32'({mmcm_daddr, mmcm_di}), 32'd0);

    // Plain read, drdy one cycle after den
    mem[8] = 16'h1234; ref_mem[8] = 16'h1234;
    d0 = den_cnt; w0 = dwe_cnt;
    applyStimulus(1'b0, 7'h08, 16'h0, 16'h0, 3);
    waitIdle(50);
    checkOutput("read_den_pulses", 32'(den_cnt - d0), 32'd1);
    checkOutput("read_dwe_pulses", 32'(dwe_cnt - w0), 32'd0);

    // Masked read-modify-write
    mem[9] = 16'h5A77; ref_mem[9] = 16'h5A77;
    d0 = den_cnt; w0 = dwe_cnt;
    applyStimulus(1'b1, 7'h09, 16'h00AB, 16'hFF00, 0);
    waitIdle(100);
    checkOutput("rmw_den_pulses", 32'(den_cnt - d0), 32'd2);
    checkOutput("rmw_dwe_pulses", 32'(dwe_cnt - w0), 32'd1);
    checkOutput("rmw_dwe_on_second", 32'(last_dwe), 32'd1);
    checkOutput("rmw_di", 32'(last_di), 32'h5AAB);
    checkOutput("rmw_rst_during_wr", 32'(rst_at_wr), 32'(AUTO));

    // Full overwrite with zero mask
    mem[10] = 16'hFFFF; ref_mem[10] = 16'hFFFF;
    applyStimulus(1'b1, 7'h0A, 16'h1357, 16'h0000, 0);
    waitIdle(100);
    checkOutput("overwrite_di", 32'(last_di), 32'h1357);

    // Mixed reads/writes with varying drdy delay
    for (int i = 0; i < 6; i++) begin
      logic dw;
      rd_lat = $urandom_range(1, 4);
      wr_lat = $urandom_range(1, 4);
      dw = 1'($urandom_range(0, 1));
      applyStimulus(dw, 7'(8'h40 + $urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                    (!dw && rd_lat == 1) ? 3 : 0);
      waitIdle(100);
    end
    rd_lat = 1; wr_lat = 1;
    for (int i = 0; i < 4; i++) checkOutput("mem_after_mix", 32'(mem[8'h40 + i]), 32'(ref_mem[8'h40 + i]));

    // Timeout: drdy never arrives
    drdy_on = 1'b0;
    applyStimulus(1'b0, 7'h03, 16'h0, 16'h0, TO + 2);
    waitIdle(TO + 40);
    checkOutput("timeout_sticky", 32'(timeout_err), 32'd1);
    checkOutput("timeout_rst_low", 32'(mmcm_rst), 32'd0);
    drdy_on = 1'b1;
    applyStimulus(1'b0, 7'h04, 16'h0, 16'h0, 3);
    checkOutput("timeout_cleared_by_req", 32'(timeout_err), 32'd0);
    waitIdle(50);

    // req_den during the req_done cycle is discarded
    d0 = den_cnt;
    applyStimulus(1'b0, 7'h05, 16'h0, 16'h0, 3);
    repeat (2) @(negedge clk_usb);
    checkOutput("done_cycle_seen", 32'(req_done), 32'd1);
    issueRaw(1'b0, 7'h06, 16'h0, 16'h0);
    waitIdle(50);
    checkOutput("done_cycle_den_pulses", 32'(den_cnt - d0), 32'd1);
    checkOutput("done_cycle_overrun", 32'(overrun_err), 32'd1);

    doReset();
    checkOutput("overrun_reset", 32'(overrun_err), 32'd0);

    // Back-to-back request while busy
    d0 = den_cnt; dc0 = done_cnt;
    applyStimulus(1'b0, 7'h10, 16'h0, 16'h0, 3);
    issueRaw(1'b1, 7'h11, 16'hFFFF, 16'h0000);
    waitIdle(50);
    checkOutput("overrun_flag", 32'(overrun_err), 32'd1);
    checkOutput("overrun_den_pulses", 32'(den_cnt - d0), 32'd1);
    checkOutput("overrun_done_count", 32'(done_cnt - dc0), 32'd1);
    checkOutput("overrun_mem_untouched", 32'(mem[8'h11]), 32'(ref_mem[8'h11]));

    // Reset while waiting for the write acknowledge
    wr_lat = 10;
    applyStimulus(1'b1, 7'h30, 16'h0F0F, 16'h0000, 0);
    repeat (4) @(negedge clk_usb);
    checkOutput("in_wr_wait_rst", 32'(mmcm_rst), 32'(AUTO));
    reset_i = 1'b1;
    sb.delete();
    dc0 = done_cnt;
    @(negedge clk_usb);
    checkOutput("reset_mid_flags", 32'({busy, mmcm_rst, req_done}), 32'd0);
    reset_i = 1'b0;
    last_dout = '0;
    repeat (14) @(negedge clk_usb);
    checkOutput("reset_mid_no_done", 32'(done_cnt - dc0), 32'd0);
    wr_lat = 1;
    applyStimulus(1'b0, 7'h08, 16'h0, 16'h0, 3);
    waitIdle(50);

`ifdef DRP_AUTO_RESET_EN
    // Write that waits for relock after the MMCM reset
    applyStimulus(1'b1, 7'h12, 16'hBEEF, 16'h00FF, 0);
    waitIdle(300);
    checkOutput("auto_timeout_err", 32'(timeout_err), 32'd0);
    checkOutput("auto_rst_released", 32'(mmcm_rst), 32'd0);
    checkOutput("auto_locked", 32'(mmcm_locked), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmcm_drp_sequencer.md
Name: mmcm_drp_sequencer

Overview:
- Sits between the register-side DRP master and the MMCM DRP port.
- Converts single-cycle DRP read/write requests into a DRP-legal transaction: one den pulse, then wait for drdy, with timeout.
- Performs masked read-modify-write for writes.
- Optionally holds the MMCM in reset across a write and waits for lock before reporting done.

Parameters:
- pTIMEOUT, 1023: max cycles to wait for mmcm_drdy or mmcm_locked before aborting.
- pTO_WIDTH, 10: width of the timeout counter; must satisfy 2^pTO_WIDTH > pTIMEOUT.

Ports:
- clk_usb  input  1  system clock; all logic on rising edge.
- reset_i  input  1  synchronous active-high reset.
- req_addr  input  7  DRP address from register block.
- req_den  input  1  one-cycle request strobe.
- req_dwe  input  1  with req_den: 1 = write, 0 = read.
- req_din  input  16  write data.
- req_mask  input  16  bits set = keep existing MMCM bit; 0x0000 = full overwrite.
- req_dout  output  16  last read data (read request) or pre-write readback (write request).
- req_done  output  1  one-cycle pulse when a transaction ends (success or timeout).
- busy  output  1  high from the cycle after an accepted req_den until req_done.
- timeout_err  output  1  sticky; set on any timeout; cleared by reset_i or by an accepted new request.
- overrun_err  output  1  sticky; set when req_den arrives while busy; cleared only by reset_i.
- mmcm_daddr  output  7  DRP address to MMCM.
- mmcm_den  output  1  DRP enable, exactly one cycle per DRP access.
- mmcm_dwe  output  1  DRP write enable; only high together with mmcm_den.
- mmcm_di  output  16  DRP write data.
- mmcm_do  input  16  DRP read data.
- mmcm_drdy  input  1  DRP ready.
- mmcm_rst  output  1  MMCM reset.
- mmcm_locked  input  1  MMCM lock; asynchronous, 2-flop synchronized internally.

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- IDLE: on req_den, latch addr, dwe, din and mask.
  - Read -> RD.
  - Write -> RST when DRP_AUTO_RESET_EN is defined, else RD.
  - busy rises next cycle.
- RST: mmcm_rst <= 1; go to RD. mmcm_rst stays 1 until LOCK_WAIT.
- RD: mmcm_den = 1, mmcm_dwe = 0, mmcm_daddr = latched addr, for one cycle -> RD_WAIT.
- RD_WAIT: on mmcm_drdy, capture mmcm_do into req_dout.
  - Read request -> DONE.
  - Write request -> WR.
- WR: mmcm_di = (rdata & mask) | (din & ~mask); mmcm_den = mmcm_dwe = 1 for one cycle -> WR_WAIT.
- WR_WAIT: on mmcm_drdy -> LOCK_WAIT if the auto-reset feature is enabled, else DONE.
- LOCK_WAIT: mmcm_rst <= 0; counter restarts; wait for synchronized locked = 1 -> DONE.
- DONE: req_done = 1 for one cycle; busy <= 0; -> IDLE.
- Timeout:
  - Counter clears on entry to each wait state and increments each cycle in it.
  - Reaching pTIMEOUT -> timeout_err <= 1, mmcm_rst <= 0, -> DONE.
  - req_dout holds its last valid value.
- Latency: read completes with req_done 3 cycles after req_den when drdy arrives 1 cycle after den.
- mmcm_drdy outside a wait state is ignored.
- req_den while busy:
  - Request discarded, overrun_err <= 1, in-flight transaction unaffected.
  - req_den in the same cycle as req_done counts as busy and is discarded.
- reset_i mid-transaction: immediate return to IDLE, all outputs to reset values (mmcm_rst deasserts), no req_done.
- Never more than one outstanding den: no den issued in any wait state.

Optional Feature:
- Macro: DRP_AUTO_RESET_EN.
- Defined: writes traverse RST and LOCK_WAIT; mmcm_rst is high from the cycle after acceptance through WR_WAIT.
- Undefined: mmcm_rst tied 0; RST and LOCK_WAIT unreachable; mmcm_locked unused (synchronizer may be removed).
- Read path identical in both builds.

Test Plan:
- Read: req_den=1, dwe=0, addr=0x08; model drdy 1 cycle later with do=0x1234 -> one mmcm_den, mmcm_dwe=0; req_dout=0x1234; req_done 3 cycles after req_den.
- Masked write: addr=0x09, din=0x00AB, mask=0xFF00, MMCM holds 0x5A77 -> read then write; mmcm_di=0x5AAB; exactly two den pulses; mmcm_dwe high only on the second.
- Auto reset (macro defined): write; locked drops, returns 20 cycles after rst falls -> mmcm_rst high through WR_WAIT; req_done 1 cycle after synchronized lock; timeout_err=0.
- Timeout: model never asserts drdy, pTIMEOUT=16 -> req_done after 16 wait cycles; timeout_err=1; mmcm_rst=0; next accepted request clears timeout_err.
- Overrun: second req_den 1 cycle after the first -> overrun_err=1; only the first transaction's den pulses seen; one req_done.
- Reset mid-write: reset_i in WR_WAIT -> next cycle busy=0, mmcm_rst=0, no req_done; a subsequent read works normally.
